// File: rtl/wb_conbus_pkg.sv
// Shared types and constants for the round-robin Wishbone shared-bus interconnect.
package wb_conbus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int MAX_NM   = 8;
    localparam int MAX_NS   = 8;

    // Index width for n ports; a single port still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_conbus_rr_if.sv
// Bundle of all master-side and slave-side Wishbone signals around the shared bus.
interface wb_conbus_rr_if
    import wb_conbus_pkg::*;
#(
    parameter int NM = 2,
    parameter int NS = 6
);
    // Handshake: a master request is live while cyc and stb are high; the cycle
    // in which ack (or err) is high completes it, and the master may then change
    // adr/dat/sel/we or drop stb. Exactly one of ack/err terminates a transfer.
    logic [NM-1:0][WB_ADR_W-1:0] m_adr_i;
    logic [NM-1:0][WB_DAT_W-1:0] m_dat_i;
    logic [NM-1:0][WB_SEL_W-1:0] m_sel_i;
    logic [NM-1:0]               m_we_i;
    logic [NM-1:0]               m_cyc_i;
    logic [NM-1:0]               m_stb_i;
    logic [WB_DAT_W-1:0]         m_dat_o;
    logic [NM-1:0]               m_ack_o;
    logic [NM-1:0]               m_err_o;

    logic [WB_ADR_W-1:0]         s_adr_o;
    logic [WB_DAT_W-1:0]         s_dat_o;
    logic [WB_SEL_W-1:0]         s_sel_o;
    logic                        s_we_o;
    logic [NS-1:0]               s_cyc_o;
    logic [NS-1:0]               s_stb_o;
    logic [NS-1:0][WB_DAT_W-1:0] s_dat_i;
    logic [NS-1:0]               s_ack_i;

    modport conbus (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o
    );

    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus arbiter: grant is registered and held until the owner drops cyc.
module wb_rr_arbiter
    import wb_conbus_pkg::*;
#(
    parameter  int NM = 2,
    localparam int IW = idx_w(NM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NM-1:0] req,
    output arb_state_t    state,
    output logic [NM-1:0] grant_oh,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last_grant;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    int            cand;

    // First requester after last_grant, wrapping; last_grant itself is checked last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= NM; k++) begin
            cand = (int'(last_grant) + k) % NM;
            if (!pick_found && req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant_oh   <= '0;
            grant_idx  <= '0;
            last_grant <= IW'(NM - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= BUSY;
                        grant_idx <= pick_idx;
                        grant_oh  <= NM'(1) << pick_idx;
                    end
                end
                BUSY: begin
                    if (!req[grant_idx]) begin
                        state      <= IDLE;
                        grant_oh   <= '0;
                        last_grant <= grant_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_conbus_rr.sv
// Shared-bus interconnect: round-robin master arbitration, top-address slave decode,
// error on unmapped addresses and a watchdog for slaves that never acknowledge.
module wb_conbus_rr
    import wb_conbus_pkg::*;
#(
    parameter int                     NM       = 2,
    parameter int                     NS       = 6,
    parameter int                     S_ADDR_W = 3,
    parameter logic [NS*S_ADDR_W-1:0] S_ADDR   = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
    parameter int                     TIMEOUT  = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    wb_conbus_rr_if.conbus    bus,
    output arb_state_t        arb_state
);

    localparam int IW = idx_w(NM);
    localparam int SW = idx_w(NS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    arb_state_t          state;
    logic [NM-1:0]       grant_oh;
    logic [IW-1:0]       g;
    logic                busy;

    logic [WB_ADR_W-1:0] g_adr;
    logic [WB_DAT_W-1:0] g_dat;
    logic [WB_SEL_W-1:0] g_sel;
    logic                g_we;
    logic                g_cyc;
    logic                g_stb;

    logic                hit;
    logic [SW-1:0]       sidx;
    logic                sel;
    logic [NS-1:0]       s_cyc;
    logic [NS-1:0]       s_stb;
    logic                slave_ack;

    logic                dec_err_q;
    logic [CW-1:0]       wd_cnt;
    logic                wd_fire;
    logic                err_any;

    wb_rr_arbiter #(.NM(NM)) u_arb (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .req       (bus.m_cyc_i),
        .state     (state),
        .grant_oh  (grant_oh),
        .grant_idx (g)
    );

    assign busy      = (state == BUSY);
    assign arb_state = state;

    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        if (busy) begin
            g_adr = bus.m_adr_i[g];
            g_dat = bus.m_dat_i[g];
            g_sel = bus.m_sel_i[g];
            g_we  = bus.m_we_i[g];
            g_cyc = bus.m_cyc_i[g];
            g_stb = bus.m_stb_i[g];
        end
    end

    // Scan downwards so the lowest-index matching slave is the one kept.
    always_comb begin
        hit  = 1'b0;
        sidx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (g_adr[WB_ADR_W-1 -: S_ADDR_W] == S_ADDR[i*S_ADDR_W +: S_ADDR_W]) begin
                hit  = 1'b1;
                sidx = SW'(i);
            end
        end
    end

    assign sel = busy && hit;

    always_comb begin
        s_cyc = '0;
        s_stb = '0;
        if (sel) begin
            s_cyc[sidx] = g_cyc;
            s_stb[sidx] = g_stb;
        end
    end

    assign slave_ack   = sel && bus.s_ack_i[sidx];

    assign bus.s_cyc_o = s_cyc;
    assign bus.s_stb_o = s_stb;
    assign bus.s_adr_o = g_adr;
    assign bus.s_dat_o = g_dat;
    assign bus.s_sel_o = g_sel;
    assign bus.s_we_o  = g_we;
    assign bus.m_dat_o = sel ? bus.s_dat_i[sidx] : '0;

    // The watchdog only guards decoded slaves; unmapped strobes already get the decode error.
    assign wd_fire = (TIMEOUT != 0) && sel && g_stb && !slave_ack && (wd_cnt == TO_VAL);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dec_err_q <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            dec_err_q <= busy && !hit && g_stb && !dec_err_q;
            if ((TIMEOUT == 0) || !sel || !g_stb || slave_ack || wd_fire) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + CW'(1);
            end
        end
    end

    assign err_any     = (busy && dec_err_q) || wd_fire;
    assign bus.m_ack_o = slave_ack ? grant_oh : '0;
    assign bus.m_err_o = (err_any && !slave_ack) ? grant_oh : '0;

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Bench for wb_conbus_rr: decode/routing vectors plus arbitration, error, watchdog and reset sequences.
module tb_wb_conbus_rr;
    import wb_conbus_pkg::*;

    localparam int NM = 2;
    localparam int NS = 6;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    wb_conbus_rr_if #(.NM(NM), .NS(NS)) bus ();
    wb_conbus_rr_if #(.NM(NM), .NS(NS)) bus_t4 ();
    wb_conbus_rr_if #(.NM(NM), .NS(NS)) bus_t0 ();

    arb_state_t st, st_t4, st_t0;
    logic          auto_ack = 1'b0;
    logic [NS-1:0] man_ack  = '0;

    assign bus.s_ack_i = auto_ack ? bus.s_stb_o : man_ack;

    assign bus_t4.m_adr_i = bus.m_adr_i;
    assign bus_t4.m_dat_i = bus.m_dat_i;
    assign bus_t4.m_sel_i = bus.m_sel_i;
    assign bus_t4.m_we_i  = bus.m_we_i;
    assign bus_t4.m_cyc_i = bus.m_cyc_i;
    assign bus_t4.m_stb_i = bus.m_stb_i;
    assign bus_t4.s_dat_i = bus.s_dat_i;
    assign bus_t4.s_ack_i = bus.s_ack_i;
    assign bus_t0.m_adr_i = bus.m_adr_i;
    assign bus_t0.m_dat_i = bus.m_dat_i;
    assign bus_t0.m_sel_i = bus.m_sel_i;
    assign bus_t0.m_we_i  = bus.m_we_i;
    assign bus_t0.m_cyc_i = bus.m_cyc_i;
    assign bus_t0.m_stb_i = bus.m_stb_i;
    assign bus_t0.s_dat_i = bus.s_dat_i;
    assign bus_t0.s_ack_i = bus.s_ack_i;

    wb_conbus_rr #(.NM(NM), .NS(NS)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus), .arb_state(st));
    wb_conbus_rr #(.NM(NM), .NS(NS), .TIMEOUT(4)) u_dut_t4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_t4), .arb_state(st_t4));
    wb_conbus_rr #(.NM(NM), .NS(NS), .TIMEOUT(0)) u_dut_t0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_t0), .arb_state(st_t0));

    typedef struct {
        int            m;
        logic [31:0]   adr;
        logic          we;
        logic [31:0]   wdat;
        logic [3:0]    sel;
        int            lat;
        logic [31:0]   rdat;
        logic [NS-1:0] exp_stb;
        logic          exp_err;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    logic [NM-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sys_clk);
    endtask

    task automatic drive_m(input int m, input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel);
        bus.m_adr_i[m] = adr;
        bus.m_dat_i[m] = dat;
        bus.m_sel_i[m] = sel;
        bus.m_we_i[m]  = we;
        bus.m_cyc_i[m] = 1'b1;
        bus.m_stb_i[m] = 1'b1;
    endtask

    task automatic release_m(input int m);
        bus.m_cyc_i[m] = 1'b0;
        bus.m_stb_i[m] = 1'b0;
        bus.m_we_i[m]  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " s_cyc_o"}, bus.s_cyc_o, 0);
        chk({tag, " s_stb_o"}, bus.s_stb_o, 0);
        chk({tag, " m_ack_o"}, bus.m_ack_o, 0);
        chk({tag, " m_err_o"}, bus.m_err_o, 0);
        chk({tag, " s_adr_o"}, bus.s_adr_o, 0);
        chk({tag, " s_dat_o"}, bus.s_dat_o, 0);
        chk({tag, " s_sel_o"}, bus.s_sel_o, 0);
        chk({tag, " s_we_o"},  bus.s_we_o, 0);
        chk({tag, " m_dat_o"}, bus.m_dat_o, 0);
    endtask

    // One isolated transfer on an idle bus; the slave acks after v.lat wait cycles.
    task automatic run_vec(input vec_t v);
        int s;
        logic [NM-1:0] moh;
        s   = -1;
        moh = NM'(1) << v.m;
        for (int i = 0; i < NS; i++) if (v.exp_stb[i]) s = i;
        if (s >= 0) bus.s_dat_i[s] = v.rdat;
        step();
        drive_m(v.m, v.adr, v.we, v.wdat, v.sel);
        sample();
        chk("vec stb before grant", bus.s_stb_o, 0);
        if (v.exp_err) begin
            step();
            sample();
            chk("vec unmapped stb", bus.s_stb_o, 0);
            chk("vec unmapped err early", bus.m_err_o, 0);
            chk("vec unmapped dat", bus.m_dat_o, 0);
            step();
            sample();
            chk("vec unmapped err", bus.m_err_o, moh);
            chk("vec unmapped ack", bus.m_ack_o, 0);
        end else begin
            for (int k = 0; k <= v.lat; k++) begin
                step();
                if (k == v.lat) man_ack[s] = 1'b1;
                sample();
                if (k == 0) begin
                    chk("vec s_stb_o", bus.s_stb_o, v.exp_stb);
                    chk("vec s_cyc_o", bus.s_cyc_o, v.exp_stb);
                    chk("vec s_adr_o", bus.s_adr_o, v.adr);
                    chk("vec s_dat_o", bus.s_dat_o, v.wdat);
                    chk("vec s_sel_o", bus.s_sel_o, v.sel);
                    chk("vec s_we_o",  bus.s_we_o, v.we);
                end
                chk("vec m_err_o", bus.m_err_o, 0);
                if (k < v.lat) begin
                    chk("vec ack wait", bus.m_ack_o, 0);
                end else begin
                    chk("vec m_ack_o", bus.m_ack_o, moh);
                    chk("vec m_dat_o", bus.m_dat_o, v.rdat);
                end
            end
        end
        step();
        release_m(v.m);
        man_ack = '0;
        sample();
        chk("vec release s_cyc_o", bus.s_cyc_o, 0);
        chk("vec release ack/err", {bus.m_ack_o, bus.m_err_o}, 0);
        step();
        sample();
        chk("vec back to idle", st, IDLE);
    endtask

    initial begin
        logic [NM-1:0] acked;
        int last_c;
        int n_ack;

        vecs[0] = '{1, 32'h0000_0010, 1'b0, 32'h0000_0000, 4'hF,    0, 32'h1111_2222, 6'b000001, 1'b0};
        vecs[1] = '{0, 32'h4000_0004, 1'b0, 32'h0000_0000, 4'hF,    2, 32'h0000_00A5, 6'b000010, 1'b0};
        vecs[2] = '{0, 32'h8000_0004, 1'b0, 32'h0000_0000, 4'hF,    2, 32'h0000_00A5, 6'b001000, 1'b0};
        vecs[3] = '{1, 32'h6000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1, 32'h0000_0000, 6'b000100, 1'b0};
        vecs[4] = '{0, 32'hA000_0000, 1'b1, 32'h1234_5678, 4'b1000, 0, 32'h7777_0000, 6'b010000, 1'b0};
        vecs[5] = '{1, 32'hC000_00FC, 1'b0, 32'h0000_0000, 4'b0100, 3, 32'hCAFE_F00D, 6'b100000, 1'b0};
        vecs[6] = '{1, 32'hE000_0000, 1'b0, 32'h0000_0000, 4'hF,    0, 32'h0000_0000, 6'b000000, 1'b1};
        vecs[7] = '{0, 32'h2000_0000, 1'b1, 32'h55AA_55AA, 4'hF,    0, 32'h0000_0000, 6'b000000, 1'b1};
        vecs[8] = '{0, 32'h5FFF_FFFC, 1'b0, 32'h0000_0000, 4'hF,    1, 32'h0BAD_CAFE, 6'b000010, 1'b0};
        vecs[9] = '{1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'hF,    0, 32'h0000_0000, 6'b000000, 1'b1};

        // Reset with live-looking inputs: nothing may leak through.
        bus.m_adr_i = {NM{32'h8000_0000}};
        bus.m_dat_i = {NM{32'hFFFF_FFFF}};
        bus.m_sel_i = '1;
        bus.m_we_i  = '1;
        bus.m_cyc_i = '1;
        bus.m_stb_i = '1;
        bus.s_dat_i = '1;
        man_ack     = '1;
        #1 sys_rst  = 1'b1;
        sample();
        check_zero("in reset");
        sample();
        step();
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_we_i  = '0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        man_ack     = '0;
        sys_rst     = 1'b0;
        sample();
        check_zero("after reset");
        chk("state after reset", {st, st_t4, st_t0}, {IDLE, IDLE, IDLE});
        step();
        sample();
        check_zero("idle no request");

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Both masters back-to-back; the last owner was m1, so m0 goes first.
        exp_q  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        last_c = -1;
        n_ack  = 0;
        auto_ack = 1'b1;
        step();
        drive_m(0, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
        drive_m(1, 32'h0000_0200, 1'b0, 32'h0, 4'hF);
        for (int c = 0; c < 16; c++) begin
            sample();
            acked = bus.m_ack_o;
            if (acked != 0) begin
                n_ack++;
                if (exp_q.size() != 0) chk("rr grant order", acked, exp_q.pop_front());
                else chk("rr extra ack", acked, 0);
                if (last_c >= 0) chk("rr ack spacing", c - last_c, 3);
                last_c = c;
            end
            step();
            for (int m = 0; m < NM; m++) begin
                bus.m_cyc_i[m] = !acked[m];
                bus.m_stb_i[m] = !acked[m];
            end
        end
        chk("rr ack count", n_ack, 5);
        release_m(0);
        release_m(1);
        auto_ack = 1'b0;
        step();
        step();
        sample();
        chk("rr back to idle", st, IDLE);

        // Slave 2 never acks: TIMEOUT=4 errs after 4 stalled cycles, others stay silent.
        step();
        drive_m(0, 32'h6000_0000, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 12; k++) begin
            step();
            sample();
            if (k == 0) chk("wd stb slave2", bus.s_stb_o, 6'b000100);
            chk("wd t4 err", bus_t4.m_err_o, (k == 4 || k == 9) ? 2'b01 : 2'b00);
            chk("wd t4 ack", bus_t4.m_ack_o, 0);
            chk("wd t0 err", bus_t0.m_err_o, 0);
            chk("wd t255 err", bus.m_err_o, 0);
        end
        step();
        release_m(0);
        step();
        step();

        // Ack arriving exactly when the watchdog would fire wins.
        drive_m(0, 32'h6000_0000, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 4) man_ack[2] = 1'b1;
            sample();
            chk("wd race err", bus_t4.m_err_o, 0);
            chk("wd race ack", bus_t4.m_ack_o, (k == 4) ? 2'b01 : 2'b00);
        end
        step();
        release_m(0);
        man_ack = '0;
        step();
        step();

        // Unmapped strobe held: err every other cycle.
        drive_m(1, 32'hE000_0000, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 6; k++) begin
            step();
            sample();
            chk("held unmapped err", bus.m_err_o, (k % 2 == 1) ? 2'b10 : 2'b00);
            chk("held unmapped ack", bus.m_ack_o, 0);
        end
        step();
        release_m(1);
        step();
        step();

        // Reset mid-transfer, then m0 must win although m1 also requests.
        drive_m(0, 32'h8000_0000, 1'b0, 32'h0, 4'hF);
        step();
        sample();
        chk("mid-rst stb before", bus.s_stb_o, 6'b001000);
        #2;
        sys_rst    = 1'b1;
        man_ack[3] = 1'b1;
        #1;
        chk("mid-rst s_cyc_o", bus.s_cyc_o, 0);
        chk("mid-rst s_stb_o", bus.s_stb_o, 0);
        chk("mid-rst ack/err", {bus.m_ack_o, bus.m_err_o}, 0);
        chk("mid-rst s_adr_o", bus.s_adr_o, 0);
        step();
        drive_m(1, 32'h0000_0000, 1'b0, 32'h0, 4'hF);
        sample();
        chk("in rst ack/err", {bus.m_ack_o, bus.m_err_o, bus_t4.m_err_o}, 0);
        step();
        sys_rst = 1'b0;
        man_ack = '0;
        sample();
        chk("post-rst stb", bus.s_stb_o, 0);
        step();
        sample();
        chk("post-rst first grant stb", bus.s_stb_o, 6'b001000);
        chk("post-rst first grant adr", bus.s_adr_o, 32'h8000_0000);
        release_m(0);
        release_m(1);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
